fcmp_issue: RTL
===============

// Module: fcmp_issue
// PURPOSE
// Issue/collect stage around the 1-cycle registered float compares (feq, flt, fle).
// Accepts compare ops from the FPU dispatcher over valid/ready and drives all three comparators.
// Pairs each registered result with its tag and buffers it in a FIFO for the integer writeback port.
// Comparators cannot stall, so issue is credit-gated against FIFO space.
// PARAMETERS
// TAG_W    5  width of destination-register tag carried with each op
// DEPTH    4  result FIFO entries (power of 2, >=2)
// PORTS
// clk        in   1      clock
// rstn       in   1      reset, synchronous, active-low
// flush      in   1      drop all in-flight and buffered ops
// in_valid   in   1      op offered
// in_ready   out  1      op accepted when in_valid&&in_ready
// in_op      in   2      00 feq, 01 flt, 10 fle, 11 reserved
// in_x1      in   32     operand 1 (IEEE single)
// in_x2      in   32     operand 2
// in_tag     in   TAG_W  destination tag
// out_valid  out  1      result at FIFO head
// out_ready  in   1      writeback consumes when out_valid&&out_ready
// out_data   out  32     {31'b0, flag}
// out_tag    out  TAG_W  tag of head result
// out_nv     out  1      invalid-operation flag (0 unless FCMP_NAN_EN)
// BEHAVIOUR
// - Reset (rstn=0 at clk edge): FIFO empty, in-flight cleared; out_valid=0, out_data=0,
//   out_tag=0, out_nv=0, in_ready=0 during reset cycle, 1 the cycle after.
// - Compare rules (comparator-equivalent): both exponents zero -> operands equal (denormals/-0
//   flush); feq = zero||x1==x2; flt/fle sign-magnitude, ~zero required for flt, zero forces fle=1.
// - Op 11: accepted, result flag 0, out_nv=1.
// - Pipeline: accept at cycle T -> comparators register at T+1 edge; op/tag/valid shadow reg
//   (s1_valid, s1_op, s1_tag) captured alongside; result written into FIFO at T+1 edge end;
//   earliest out_valid at T+2. Latency = 2 cycles accept-to-out_valid.
// - Credit: in_ready = rstn_q && (count + s1_valid) < DEPTH. Never overflows; no drop.
// - FIFO: rd/wr pointers log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; empty rd==wr; full MSB differ.
// - Simultaneous push+pop when full: legal only because credit already reserved; count unchanged.
// - Pop on empty is ignored; out_data/out_tag hold last head value when out_valid=0.
// - flush: at edge, FIFO emptied, s1_valid cleared, any same-cycle in_valid handshake discarded;
//   out_valid=0 next cycle. flush has priority over push/pop; reset has priority over flush.
// - Outputs registered from FIFO head storage; no combinational path in_* -> out_*.
// - out_ready -> in_ready path is combinational only through count (registered); no loop.
// CONFIGURATION
// FCMP_NAN_EN defined: NaN (exp=0xFF, mant!=0) on either operand forces flag=0 for all ops;
//   out_nv=1 for flt/fle with any NaN, and for feq only with signaling NaN (mant[22]=0).
// FCMP_NAN_EN undefined: no NaN detect; raw comparator result; out_nv=1 only for op 11.
// TESTING
// 1 feq 0x3F800000,0x3F800000 tag 3 -> out_valid at T+2, out_data=1, out_tag=3, out_nv=0.
// 2 feq 0x00000000,0x80000000 -> 1; flt same -> 0; fle same -> 1 (signed zero/denormal flush).
// 3 flt 0xBF800000,0x3F800000 -> 1; flt 0x40000000,0x3F800000 -> 0; fle 0xC0000000,0xBF800000 -> 1.
// 4 out_ready=0, stream 6 ops -> in_ready drops after 4 accepted, none lost; release -> 4 in order
//   of tags 0..3, then remaining 2 accepted and delivered.
// 5 flush with 2 buffered + 1 in flight + in_valid high -> out_valid=0 next cycle, nothing emitted.
// 6 FCMP_NAN_EN: flt 0x7FC00000,0x3F800000 -> data 0, nv 1; feq 0x7FC00000,same -> 0, nv 0;
//   without macro flt same -> 0 (mag compare), nv 0.

Source files
------------

// File: rtl/fcmp_issue_if.sv
// Dispatcher/writeback bus for the float-compare issue stage: op in, tagged result out.
// The master side issues ops and consumes results; the slave side is the compare stage.
interface fcmp_issue_if #(
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_x1;
    logic [31:0]      in_x2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_nv;

    modport master (
        output flush, in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_nv
    );

    modport slave (
        input  flush, in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_nv
    );
endinterface

// File: rtl/fcmp_issue.sv
// fcmp_issue: credit-gated issue/collect stage around registered feq/flt/fle comparators.
// Define FCMP_NAN_EN to enable NaN detection (flag squash and invalid-operation reporting).
module fcmp_issue #(
    parameter int TAG_W = 5,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    fcmp_issue_if.slave bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam int            EW      = TAG_W + 2;
    localparam logic [AW+1:0] DEPTH_C = (AW+2)'(DEPTH);

    logic [7:0]       w_e1, w_e2;
    logic             w_zero, w_same, w_lt;
    logic             w_in_ready, w_accept;
    logic             w_flag, w_nv;
    logic [EW-1:0]    w_entry, w_head;
    logic             w_push, w_pop;
    logic [AW:0]      w_wr_nxt, w_rd_nxt, w_count;
    logic [AW+1:0]    w_credit_used;

    logic             r_rstn_q;
    logic             r_s1_valid;
    logic [1:0]       r_s1_op;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s1_eq, r_s1_lt, r_s1_le;
    logic [AW:0]      r_wr, r_rd;
    logic [EW-1:0]    r_mem [DEPTH];
    logic             r_out_valid, r_out_flag, r_out_nv;
    logic [TAG_W-1:0] r_out_tag;

    assign w_e1   = bus.in_x1[30:23];
    assign w_e2   = bus.in_x2[30:23];
    assign w_zero = (w_e1 == 8'd0) && (w_e2 == 8'd0);
    assign w_same = (bus.in_x1 == bus.in_x2);

    // Sign-magnitude ordering of the raw encodings
    always_comb begin
        w_lt = 1'b0;
        case ({bus.in_x1[31], bus.in_x2[31]})
            2'b00:   w_lt = (bus.in_x1[30:0] < bus.in_x2[30:0]);
            2'b11:   w_lt = (bus.in_x2[30:0] < bus.in_x1[30:0]);
            2'b10:   w_lt = 1'b1;
            default: w_lt = 1'b0;
        endcase
    end

`ifdef FCMP_NAN_EN
    logic w_nan1, w_nan2, w_snan;
    logic r_s1_nan, r_s1_snan;

    assign w_nan1 = (w_e1 == 8'hFF) && (bus.in_x1[22:0] != 23'd0);
    assign w_nan2 = (w_e2 == 8'hFF) && (bus.in_x2[22:0] != 23'd0);
    assign w_snan = (w_nan1 && !bus.in_x1[22]) || (w_nan2 && !bus.in_x2[22]);

    // NaN classification registered alongside the comparator outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_s1_nan  <= 1'b0;
            r_s1_snan <= 1'b0;
        end else if (w_accept) begin
            r_s1_nan  <= w_nan1 || w_nan2;
            r_s1_snan <= w_snan;
        end else begin
            r_s1_nan  <= r_s1_nan;
            r_s1_snan <= r_s1_snan;
        end
    end

    // Result selection: any NaN squashes the flag; feq only signals on sNaN
    always_comb begin
        w_flag = 1'b0;
        w_nv   = 1'b0;
        case (r_s1_op)
            2'b00: begin
                w_flag = r_s1_eq && !r_s1_nan;
                w_nv   = r_s1_snan;
            end
            2'b01: begin
                w_flag = r_s1_lt && !r_s1_nan;
                w_nv   = r_s1_nan;
            end
            2'b10: begin
                w_flag = r_s1_le && !r_s1_nan;
                w_nv   = r_s1_nan;
            end
            default: begin
                w_flag = 1'b0;
                w_nv   = 1'b1;
            end
        endcase
    end
`else
    // Result selection from the raw comparator outputs
    always_comb begin
        w_flag = 1'b0;
        w_nv   = 1'b0;
        case (r_s1_op)
            2'b00:   w_flag = r_s1_eq;
            2'b01:   w_flag = r_s1_lt;
            2'b10:   w_flag = r_s1_le;
            default: begin
                w_flag = 1'b0;
                w_nv   = 1'b1;
            end
        endcase
    end
`endif

    // Credit counts buffered results plus the one possibly in the comparator stage
    assign w_count       = r_wr - r_rd;
    assign w_credit_used = {1'b0, w_count} + {{(AW+1){1'b0}}, r_s1_valid};
    assign w_in_ready    = r_rstn_q && (w_credit_used < DEPTH_C);
    assign w_accept      = bus.in_valid && w_in_ready && !bus.flush;

    assign w_entry  = {w_nv, w_flag, r_s1_tag};
    assign w_push   = r_s1_valid;
    assign w_pop    = r_out_valid && bus.out_ready;
    assign w_wr_nxt = r_wr + {{AW{1'b0}}, w_push};
    assign w_rd_nxt = r_rd + {{AW{1'b0}}, w_pop};

    // Next head: bypass the entry being written when it lands at the head slot
    always_comb begin
        w_head = '0;
        if (w_push && (w_rd_nxt == r_wr)) begin
            w_head = w_entry;
        end else begin
            w_head = r_mem[w_rd_nxt[AW-1:0]];
        end
    end

    // Reset-release qualifier for in_ready
    always_ff @(posedge clk) begin
        r_rstn_q <= rstn;
    end

    // Comparator stage: registered compare results with op/tag shadow
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= 2'b00;
            r_s1_tag   <= '0;
            r_s1_eq    <= 1'b0;
            r_s1_lt    <= 1'b0;
            r_s1_le    <= 1'b0;
        end else if (bus.flush) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_op  <= bus.in_op;
                r_s1_tag <= bus.in_tag;
                r_s1_eq  <= w_zero || w_same;
                r_s1_lt  <= !w_zero && w_lt;
                r_s1_le  <= w_zero || w_lt || w_same;
            end
        end
    end

    // Result storage; credit guarantees a free slot whenever a push arrives
    always_ff @(posedge clk) begin
        if (rstn && !bus.flush && w_push) begin
            r_mem[r_wr[AW-1:0]] <= w_entry;
        end
    end

    // FIFO pointers and registered head view driving the writeback port
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_out_valid <= 1'b0;
            r_out_flag  <= 1'b0;
            r_out_nv    <= 1'b0;
            r_out_tag   <= '0;
        end else if (bus.flush) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_wr        <= w_wr_nxt;
            r_rd        <= w_rd_nxt;
            r_out_valid <= (w_wr_nxt != w_rd_nxt);
            if (w_wr_nxt != w_rd_nxt) begin
                {r_out_nv, r_out_flag, r_out_tag} <= w_head;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = {31'd0, r_out_flag};
    assign bus.out_tag   = r_out_tag;
    assign bus.out_nv    = r_out_nv;
endmodule
